// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply unit: opcodes, FSM states, defaults.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_CNT_W = 6;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_MADD  = 3'b010;
    localparam logic [2:0] MDU_MSUB  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } mdu_state_e;

    // Ops that occupy the shift-add core.
    function automatic logic mdu_is_mul(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

    // Multiply ops that treat operands as two's complement.
    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

endpackage

// File: rtl/mdu_shift_add_core.sv
// Radix-2 shift-add multiplier datapath: one add/shift step per enabled cycle.
// Operands are unsigned magnitudes; sign handling lives in the caller.
module mdu_shift_add_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] product_o
);

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH:0]     upper_sum;

    // Upper half plus optional multiplicand; the carry becomes the new top bit after the shift.
    always_comb begin
        upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (mplier_q[0]) begin
            upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end
    end

    // Operand load and per-cycle add/shift step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if (load_i) begin
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            prod_q   <= '0;
        end else if (step_i) begin
            mplier_q <= mplier_q >> 1;
            prod_q   <= {upper_sum, prod_q[WIDTH-1:1]};
        end
    end

    assign product_o = prod_q;

endmodule

// File: rtl/hilo_mdu_sequencer.sv
// Multi-cycle multiply unit owning architectural HI/LO. Runs MULT/MULTU/MADD/MSUB
// through the shift-add core, handles MTHI/MTLO directly, and stalls MFHI/MFLO
// while a multiply is in flight.
module hilo_mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = MDU_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MfReq,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic               sign_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               start_mul;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] p_signed;
    logic [2*WIDTH-1:0] result;

    assign start_mul = (state_q == StIdle) && Start && mdu_is_mul(Op);
    assign op_signed = mdu_is_signed(Op);

    // Operand magnitudes for the unsigned core; most-negative value maps to its unsigned magnitude.
    always_comb begin
        a_mag = A;
        b_mag = B;
        if (op_signed && A[WIDTH-1]) a_mag = -A;
        if (op_signed && B[WIDTH-1]) b_mag = -B;
    end

    mdu_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .load_i    (start_mul),
        .step_i    (state_q == StRun),
        .mcand_i   (a_mag),
        .mplier_i  (b_mag),
        .product_o (product)
    );

    // Apply the sign and fold in the accumulator snapshot for MADD/MSUB.
    always_comb begin
        p_signed = sign_q ? -product : product;
        result   = p_signed;
        case (op_q)
            MDU_MADD: result = acc_q + p_signed;
            MDU_MSUB: result = acc_q - p_signed;
            default:  result = p_signed;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_mul) state_d = StRun;
            StRun:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Iteration counter, launch snapshot, HI/LO writeback and Done pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            op_q   <= MDU_MULT;
            sign_q <= 1'b0;
            acc_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == StFin);
            if (start_mul) begin
                cnt_q  <= '0;
                op_q   <= Op;
                sign_q <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                acc_q  <= {hi_q, lo_q};
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == StFin) begin
                {hi_q, lo_q} <= result;
            end else if (state_q == StIdle && Start && Op == MDU_MTHI) begin
                hi_q <= A;
            end else if (state_q == StIdle && Start && Op == MDU_MTLO) begin
                lo_q <= A;
            end
        end
    end

    assign Busy  = (state_q != StIdle);
    assign Done  = done_q;
    assign Stall = MfReq & (Busy | start_mul);
    assign Hi    = hi_q;
    assign Lo    = lo_q;

endmodule

// File: tb/tb_hilo_mdu_sequencer.sv
// Scoreboard bench for hilo_mdu_sequencer: a 64-bit reference model predicts
// HI/LO for each multiply, the expectation is queued at issue and compared on Done.
module tb_hilo_mdu_sequencer;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         mf_req;
    logic         busy, done, stall;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];
    logic [63:0] model_acc;

    hilo_mdu_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .Start (start),
        .Op    (op),
        .A     (a),
        .B     (b),
        .MfReq (mf_req),
        .Busy  (busy),
        .Done  (done),
        .Stall (stall),
        .Hi    (hi),
        .Lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: full-width signed/unsigned product, then accumulate on the model HI/LO.
    function automatic logic [63:0] model_next(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0]        p;
        sx = $signed(x);
        sy = $signed(y);
        if (o == OP_MULTU) p = {32'b0, x} * {32'b0, y};
        else               p = sx * sy;
        case (o)
            OP_MADD: return model_acc + p;
            OP_MSUB: return model_acc - p;
            default: return p;
        endcase
    endfunction

    // Scoreboard consumer: every Done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("done_unexpected", {63'b0, done}, 64'b0);
            end else begin
                check_eq("sb_hilo", {hi, lo}, sb_q.pop_front());
            end
        end
    end

    // Issue a multiply at a negedge; returns at the negedge where Done is seen.
    // abort_at > 0 pulses Reset at that RUN iteration; extra_start pokes Start mid-run.
    task automatic run_mul(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input int abort_at, input bit extra_start);
        logic [63:0] exp;
        int          k;
        exp = model_next(o, x, y);
        if (abort_at <= 0) sb_q.push_back(exp);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        #1;
        if (mf_req) check_eq("stall_start", {63'b0, stall}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        for (k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1) break;
            if (abort_at == k) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq("abort_busy", {63'b0, busy}, 64'd0);
                check_eq("abort_hilo", {hi, lo}, 64'd0);
                model_acc = 64'd0;
                repeat (40) @(negedge clk);
                return;
            end
            if (k == 1 || k == W + 1) check_eq("busy_run", {63'b0, busy}, 64'd1);
            if (k == 5) check_eq("hilo_stable", {hi, lo}, model_acc);
            if (mf_req) check_eq("stall_busy", {63'b0, stall}, 64'd1);
            if (extra_start && k == 10) begin
                op    = OP_MULT;
                a     = 32'd1234;
                b     = 32'd77;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check_eq("latency", 64'(k), 64'(W + 2));
        if (mf_req) check_eq("stall_done", {63'b0, stall}, 64'd0);
        check_eq("result", {hi, lo}, exp);
        model_acc = exp;
    endtask

    // MTHI/MTLO and reserved ops: single-cycle, no Busy/Done.
    task automatic run_move(input logic [2:0] o, input logic [31:0] x);
        op    = o;
        a     = x;
        b     = 32'hDEAD_BEEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (o == OP_MTHI) model_acc[63:32] = x;
        if (o == OP_MTLO) model_acc[31:0]  = x;
        check_eq("move_busy", {62'b0, busy, done}, 64'd0);
        check_eq("move_hilo", {hi, lo}, model_acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        op        = OP_MULT;
        a         = '0;
        b         = '0;
        mf_req    = 1'b0;
        model_acc = 64'd0;
        repeat (2) @(negedge clk);
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        check_eq("reset_flags", {61'b0, busy, done, stall}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_mul(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
        check_eq("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        // Back-to-back: Start issued in the Done cycle.
        run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check_eq("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_mul(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check_eq("mult_m1m1", {hi, lo}, 64'd1);

        run_move(OP_MTHI, 32'd0);
        run_move(OP_MTLO, 32'h10);
        run_mul(OP_MADD, 32'd2, 32'd3, 0, 1'b0);
        check_eq("madd", {hi, lo}, 64'h0000_0000_0000_0016);
        run_mul(OP_MSUB, 32'h20, 32'd1, 0, 1'b0);
        check_eq("msub", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF6);

        run_move(3'b110, 32'h5555_5555);
        run_move(3'b111, 32'hAAAA_AAAA);

        mf_req = 1'b1;
        run_mul(OP_MULT, 32'h8000_0000, 32'd3, 0, 1'b1);
        mf_req = 1'b0;
        @(negedge clk);
        check_eq("idle_after", {63'b0, busy}, 64'd0);

        run_mul(OP_MULT, 32'h0012_3456, 32'hFFFF_0001, 10, 1'b0);
        run_mul(OP_MULT, 32'd7, 32'd6, 0, 1'b0);
        check_eq("after_abort", {hi, lo}, 64'd42);

        for (int i = 0; i < 6; i++) begin
            run_mul(3'($urandom_range(0, 3)), $urandom, $urandom, 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
